// File: rtl/bus_arb_pkg.sv
// Shared types and sizes for the CPU/DMA memory bus arbiter.
package bus_arb_pkg;

  localparam int WORD_SIZE = 16;
  localparam int LINE_SIZE = 4 * WORD_SIZE;
  localparam int ADDR_W    = 16;
  localparam int GCNT_W    = 16;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    DRAIN    = 2'd1,
    DMA_OWN  = 2'd2,
    HANDBACK = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between CPU, DMA engine, memory port and the arbiter.
// slave = arbiter side, master = surrounding system side.
interface mem_bus_arbiter_if;
  import bus_arb_pkg::*;

  logic                 cpu_req;
  logic                 cpu_busy;
  logic                 cpu_read;
  logic                 cpu_write;
  logic [ADDR_W-1:0]    cpu_addr;
  logic [LINE_SIZE-1:0] cpu_wdata;
  logic                 cpu_stall;
  logic                 BR;
  logic                 BG;
  logic                 dma_write;
  logic [ADDR_W-1:0]    dma_addr;
  logic [LINE_SIZE-1:0] dma_wdata;
  logic                 mem_read;
  logic                 mem_write;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_SIZE-1:0] mem_wdata;
  logic [GCNT_W-1:0]    grant_cnt;

  modport slave (
    input  cpu_req, cpu_busy, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  BR, dma_write, dma_addr, dma_wdata,
    output cpu_stall, BG, mem_read, mem_write, mem_addr, mem_wdata, grant_cnt
  );

  modport master (
    output cpu_req, cpu_busy, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output BR, dma_write, dma_addr, dma_wdata,
    input  cpu_stall, BG, mem_read, mem_write, mem_addr, mem_wdata, grant_cnt
  );

endinterface

// File: rtl/arb_hold_timer.sv
// DMA hold-limit timer: counts consecutive DMA_OWN cycles and, after a
// preemption, keeps the CPU on the bus for a minimum window.
module arb_hold_timer #(
  parameter int MAX_HOLD = 64,
  parameter int CPU_WIN  = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_dma_own,
  input  logic i_cpu_own,
  input  logic i_cpu_req,
  output logic o_preempt,
  output logic o_win_block
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int WW = $clog2(CPU_WIN + 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  // The CPU_WIN-th CPU_OWN cycle may already sample BR, so load one less.
  localparam logic [WW-1:0] WIN_LOAD  = WW'((CPU_WIN > 0) ? CPU_WIN - 1 : 0);

  logic [HW-1:0] r_hold;
  logic [WW-1:0] r_win;
  logic          w_hold_hit;

  assign w_hold_hit  = (r_hold >= HOLD_LAST);
  assign o_preempt   = i_dma_own & w_hold_hit & i_cpu_req;
  assign o_win_block = (r_win != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
      r_win  <= '0;
    end else begin
      if (!i_dma_own)
        r_hold <= '0;
      else if (!w_hold_hit)
        r_hold <= r_hold + 1'b1;

      if (o_preempt)
        r_win <= WIN_LOAD;
      else if (i_cpu_own && (r_win != '0))
        r_win <= r_win - 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA memory bus arbiter: BR/BG handshake, CPU drain, stall and bus mux.
// Optional DMA hold limit with CPU re-entry window when ARB_HOLD_LIMIT_EN is defined.
module mem_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  parameter int CPU_WIN  = 4
) (
  input logic              CLK,
  input logic              reset_n,
  mem_bus_arbiter_if.slave bus
);

  arb_state_e           r_state;
  arb_state_e           w_next;
  logic                 r_bg;
  logic [GCNT_W-1:0]    r_grant_cnt;
  logic                 w_preempt;
  logic                 w_win_block;
  logic                 w_dma_own;
  logic                 w_cpu_own;
  logic                 w_mem_read;
  logic                 w_mem_write;
  logic [ADDR_W-1:0]    w_mem_addr;
  logic [LINE_SIZE-1:0] w_mem_wdata;

  assign w_dma_own = (r_state == DMA_OWN);
  assign w_cpu_own = (r_state == CPU_OWN);

`ifdef ARB_HOLD_LIMIT_EN
  arb_hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CPU_WIN  (CPU_WIN)
  ) u_hold_timer (
    .i_clk       (CLK),
    .i_rst_n     (reset_n),
    .i_dma_own   (w_dma_own),
    .i_cpu_own   (w_cpu_own),
    .i_cpu_req   (bus.cpu_req),
    .o_preempt   (w_preempt),
    .o_win_block (w_win_block)
  );
`else
  logic [31:0] w_cfg_unused;
  assign w_cfg_unused = 32'(MAX_HOLD) ^ 32'(CPU_WIN);
  assign w_preempt    = 1'b0;
  assign w_win_block  = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      CPU_OWN: begin
        if (bus.BR && !w_win_block)
          w_next = bus.cpu_busy ? DRAIN : DMA_OWN;
      end
      DRAIN: begin
        if (!bus.BR)
          w_next = CPU_OWN;
        else if (!bus.cpu_busy)
          w_next = DMA_OWN;
      end
      DMA_OWN: begin
        if (!bus.BR || w_preempt)
          w_next = HANDBACK;
      end
      HANDBACK: w_next = CPU_OWN;
      default:  w_next = CPU_OWN;
    endcase
  end

  // BG is registered from the next state so it tracks DMA_OWN exactly.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CPU_OWN;
      r_bg        <= 1'b0;
      r_grant_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_bg    <= (w_next == DMA_OWN);
      if ((w_next == DMA_OWN) && (r_state != DMA_OWN))
        r_grant_cnt <= r_grant_cnt + 1'b1;
    end
  end

  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      CPU_OWN, DRAIN: begin
        w_mem_read  = bus.cpu_read;
        w_mem_write = bus.cpu_write;
        w_mem_addr  = bus.cpu_addr;
        w_mem_wdata = bus.cpu_wdata;
      end
      DMA_OWN: begin
        w_mem_write = bus.dma_write;
        w_mem_addr  = bus.dma_addr;
        w_mem_wdata = bus.dma_wdata;
      end
      default: begin
      end
    endcase
  end

  // A CPU op still in flight during DRAIN is allowed to finish unstalled.
  assign bus.cpu_stall = bus.cpu_req & (r_state != CPU_OWN) &
                         ~((r_state == DRAIN) & bus.cpu_busy);
  assign bus.BG        = r_bg;
  assign bus.grant_cnt = r_grant_cnt;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

endmodule
